// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the N-approach traffic light controller.
//   RED/YELLOW/GREEN : per-approach lamp codes, encoded {red, yellow, green}
//   phase_e          : controller phase, also driven out on the phase port
//   lamp_for()       : lamp code shown by the approach that owns the phase
package tl_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

  // All-red and walk phases keep even the owning approach on RED.
  function automatic logic [2:0] lamp_for(input phase_e ph);
    logic [2:0] lamp;
    case (ph)
      PH_GREEN:  lamp = GREEN;
      PH_YELLOW: lamp = YELLOW;
      default:   lamp = RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// tl_rr_pick: combinational rotating first-set finder.
// Searches req[cur+1], req[cur+2], ... modulo N_DIR, never req[cur] itself.
//   req      in  N_DIR          request bits
//   cur      in  $clog2(N_DIR)  current index (search starts just after it)
//   found    out 1              some request other than cur is set
//   next_idx out $clog2(N_DIR)  first set index in rotation order (cur if none)
module tl_rr_pick #(
  parameter int unsigned N_DIR = 4
) (
  input  logic [N_DIR-1:0]         req,
  input  logic [$clog2(N_DIR)-1:0] cur,
  output logic                     found,
  output logic [$clog2(N_DIR)-1:0] next_idx
);

  localparam int unsigned IDX_W = $clog2(N_DIR);

  int pos;

  // Walk from the farthest offset back to the nearest so the nearest set
  // request is the last one written and therefore wins.
  always_comb begin
    found    = 1'b0;
    next_idx = cur;
    pos      = 0;
    for (int k = int'(N_DIR) - 1; k >= 1; k--) begin
      pos = int'(cur) + k;
      if (pos >= int'(N_DIR)) pos = pos - int'(N_DIR);
      if (req[pos[IDX_W-1:0]]) begin
        found    = 1'b1;
        next_idx = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/traffic_light_nway.sv
// traffic_light_nway: N-approach round-robin traffic light controller.
// Serves approaches in rotation on vehicle demand, with bounded green time
// and fixed yellow / all-red clearance between greens. Approach 0 is home.
// Compile-time option TL_PED_EN adds a pedestrian all-red walk phase.
//
// Ports:
//   clk        in  1          clock, rising edge
//   rst_n      in  1          asynchronous active-low reset
//   sensor     in  N_DIR      per-approach demand, synchronous to clk
//   lights     out 3*N_DIR    lamps, approach i at [3i+2:3i] = {red,yellow,green}
//   active_dir out clog2(N)   approach owning green/yellow (next one during all-red)
//   phase      out 2          0=ALLRED 1=GREEN 2=YELLOW 3=WALK
//   ped_req    in  1          pedestrian request (TL_PED_EN only)
//   ped_walk   out 1          walk lamp (TL_PED_EN only)
//
// state     | meaning
// PH_ALLRED | clearance, all lamps red, active_dir already holds next approach
// PH_GREEN  | active approach green, exit rule evaluated every cycle
// PH_YELLOW | active approach yellow, next approach latched
// PH_WALK   | pedestrian walk, all lamps red, ped_walk high (TL_PED_EN)
module traffic_light_nway
  import tl_pkg::*;
#(
  parameter int unsigned N_DIR     = 4,
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 32,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_DIR-1:0]         sensor,
  output logic [3*N_DIR-1:0]       lights,
  output logic [$clog2(N_DIR)-1:0] active_dir,
`ifdef TL_PED_EN
  output logic [1:0]               phase,
  input  logic                     ped_req,
  output logic                     ped_walk
`else
  output logic [1:0]               phase
`endif
);

  localparam int unsigned DIR_W = $clog2(N_DIR);

  // The counter holds (elapsed cycles - 1) in the current phase, so a phase
  // of length T ends on the edge where the counter equals T-1.
  localparam logic [CNT_W-1:0] MIN_TC    = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] MAX_TC    = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_TC = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_TC = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_TC   = CNT_W'(WALK_T - 1);

  phase_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIR_W-1:0]   active_q, active_d;
  logic [DIR_W-1:0]   next_q, next_d;
  logic [3*N_DIR-1:0] lights_q, lights_d;

  logic             other_sensor;
  logic [DIR_W-1:0] rr_idx;
  logic             ped_dem;
  logic             min_ok, max_ok;
  logic             green_exit;
  logic [DIR_W-1:0] exit_dir;

  tl_rr_pick #(.N_DIR(N_DIR)) u_rr_pick (
    .req      (sensor),
    .cur      (active_q),
    .found    (other_sensor),
    .next_idx (rr_idx)
  );

`ifdef TL_PED_EN
  logic ped_pending_q, ped_walk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending_q <= 1'b0;
      ped_walk_q    <= 1'b0;
    end else begin
      ped_walk_q <= (state_d == PH_WALK);
      // Entering WALK serves the request, so the clear takes precedence.
      if (state_q == PH_YELLOW && state_d == PH_WALK)
        ped_pending_q <= 1'b0;
      else if (ped_req && state_q != PH_WALK)
        ped_pending_q <= 1'b1;
    end
  end

  assign ped_dem  = ped_pending_q;
  assign ped_walk = ped_walk_q;
`else
  assign ped_dem = 1'b0;
`endif

  assign min_ok = (cnt_q >= MIN_TC);
  assign max_ok = (cnt_q >= MAX_TC);

  assign green_exit =
      (min_ok && (other_sensor || ped_dem) && !sensor[active_q]) ||
      (max_ok && (other_sensor || ped_dem)) ||
      (min_ok && (active_q != '0) && (sensor == '0));

  // No other sensor: stay put for a pedestrian-only exit, else go home.
  assign exit_dir = other_sensor ? rr_idx : (ped_dem ? active_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    active_d = active_q;
    next_d   = next_q;
    case (state_q)
      PH_ALLRED: begin
        if (cnt_q >= ALLRED_TC) begin
          state_d = PH_GREEN;
          cnt_d   = '0;
        end
      end
      PH_GREEN: begin
        if (green_exit) begin
          state_d = PH_YELLOW;
          cnt_d   = '0;
          next_d  = exit_dir;
        end else if (max_ok) begin
          cnt_d = cnt_q;
        end
      end
      PH_YELLOW: begin
        if (cnt_q >= YELLOW_TC) begin
          state_d  = ped_dem ? PH_WALK : PH_ALLRED;
          cnt_d    = '0;
          active_d = next_q;
        end
      end
      PH_WALK: begin
        if (cnt_q >= WALK_TC) begin
          state_d = PH_ALLRED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PH_ALLRED;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamps are decoded from next-state values so they change in step with phase.
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < int'(N_DIR); i++) begin
      lights_d[3*i +: 3] = (DIR_W'(i) == active_d) ? lamp_for(state_d) : RED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_ALLRED;
      cnt_q    <= '0;
      active_q <= '0;
      next_q   <= '0;
      lights_q <= {N_DIR{RED}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      next_q   <= next_d;
      lights_q <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign active_dir = active_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_light_nway.sv
// Testbench for traffic_light_nway with default parameters (N_DIR=4).
// Stimulus pushes per-cycle expected outputs into a queue; the monitor pops
// one entry per falling edge and compares it with the DUT outputs.
module tb_traffic_light_nway;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sensor = 4'b0000;
  logic [11:0] lights;
  logic [1:0]  active_dir;
  logic [1:0]  phase;
`ifdef TL_PED_EN
  logic        ped_req = 1'b0;
  logic        ped_walk;
`endif

  always #5 clk = ~clk;

  traffic_light_nway #(
    .N_DIR(4), .GREEN_MIN(8), .GREEN_MAX(32), .YELLOW_T(3),
    .ALLRED_T(2), .WALK_T(10), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor     (sensor),
    .lights     (lights),
    .active_dir (active_dir),
`ifdef TL_PED_EN
    .phase      (phase),
    .ped_req    (ped_req),
    .ped_walk   (ped_walk)
`else
    .phase      (phase)
`endif
  );

  typedef struct packed {
    logic [3:0]  id;
    logic        walk;
    logic [1:0]  dir;
    logic [1:0]  ph;
    logic [11:0] lamps;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic       mon_walk;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] cur_id = 4'd0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
`ifdef TL_PED_EN
      mon_walk = ped_walk;
`else
      mon_walk = 1'b0;
`endif
      n_checks++;
      if (lights !== mon_e.lamps || phase !== mon_e.ph ||
          active_dir !== mon_e.dir || mon_walk !== mon_e.walk) begin
        n_fail++;
        $display("FAIL scn%0d_out @%0t: got lights=%h phase=%0d dir=%0d walk=%b, expected lights=%h phase=%0d dir=%0d walk=%b",
                 mon_e.id, $time, lights, phase, active_dir, mon_walk,
                 mon_e.lamps, mon_e.ph, mon_e.dir, mon_e.walk);
      end
    end
  end

  task automatic push(input logic [11:0] l, input logic [1:0] p,
                      input logic [1:0] d, input logic w, input int n);
    exp_t e;
    e.id = cur_id; e.walk = w; e.dir = d; e.ph = p; e.lamps = l;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scn%0d_drain: %0d expected samples pending after %0d cycles, required 0",
               cur_id, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Asserts reset just after a rising edge, so the next sample (with no
  // clock edge in between) shows the asynchronous reset values.
  task automatic reset_to(input logic [3:0] s, input logic [3:0] id);
    @(posedge clk);
    #1;
    cur_id = id;
    sensor = s;
`ifdef TL_PED_EN
    ped_req = 1'b0;
`endif
    push(12'h924, 2'd0, 2'd0, 1'b0, 5);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: no demand, home approach green indefinitely
    reset_to(4'b0000, 4'd1);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 20);
    drain(100);

    // 2: demand on approach 2 only, exit exactly at GREEN_MIN
    reset_to(4'b0100, 4'd2);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 8);
    push(12'h922, 2'd2, 2'd0, 1'b0, 3);
    push(12'h924, 2'd0, 2'd2, 1'b0, 2);
    push(12'h864, 2'd1, 2'd2, 1'b0, 10);
    drain(100);

    // 3: home keeps demanding, exit at GREEN_MAX
    reset_to(4'b0011, 4'd3);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 32);
    push(12'h922, 2'd2, 2'd0, 1'b0, 3);
    push(12'h924, 2'd0, 2'd1, 1'b0, 2);
    push(12'h90C, 2'd1, 2'd1, 1'b0, 5);
    drain(100);

    // 4: rotation from approach 1 with sensor=1101 -> 2, 3, 0
    reset_to(4'b0010, 4'd4);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 8);
    push(12'h922, 2'd2, 2'd0, 1'b0, 3);
    push(12'h924, 2'd0, 2'd1, 1'b0, 2);
    push(12'h90C, 2'd1, 2'd1, 1'b0, 1);
    drain(100);
    sensor = 4'b1101;
    push(12'h90C, 2'd1, 2'd1, 1'b0, 7);
    push(12'h914, 2'd2, 2'd1, 1'b0, 3);
    push(12'h924, 2'd0, 2'd2, 1'b0, 2);
    push(12'h864, 2'd1, 2'd2, 1'b0, 32);
    push(12'h8A4, 2'd2, 2'd2, 1'b0, 3);
    push(12'h924, 2'd0, 2'd3, 1'b0, 2);
    push(12'h324, 2'd1, 2'd3, 1'b0, 32);
    push(12'h524, 2'd2, 2'd3, 1'b0, 3);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 5);
    drain(300);

    // 5: approach 3 loses all demand, returns home after GREEN_MIN
    reset_to(4'b1000, 4'd5);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 8);
    push(12'h922, 2'd2, 2'd0, 1'b0, 3);
    push(12'h924, 2'd0, 2'd3, 1'b0, 2);
    push(12'h324, 2'd1, 2'd3, 1'b0, 1);
    drain(100);
    sensor = 4'b0000;
    push(12'h324, 2'd1, 2'd3, 1'b0, 7);
    push(12'h524, 2'd2, 2'd3, 1'b0, 3);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 10);
    drain(100);

    // 6: sensor change during yellow keeps the latched choice (2)
    reset_to(4'b0100, 4'd6);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 8);
    push(12'h922, 2'd2, 2'd0, 1'b0, 1);
    drain(100);
    sensor = 4'b0010;
    push(12'h922, 2'd2, 2'd0, 1'b0, 2);
    push(12'h924, 2'd0, 2'd2, 1'b0, 2);
    push(12'h864, 2'd1, 2'd2, 1'b0, 8);
    push(12'h8A4, 2'd2, 2'd2, 1'b0, 3);
    push(12'h924, 2'd0, 2'd1, 1'b0, 2);
    push(12'h90C, 2'd1, 2'd1, 1'b0, 3);
    drain(100);

    // 7: long home green past GREEN_MAX, then new demand exits at once
    reset_to(4'b0001, 4'd7);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 40);
    drain(100);
    sensor = 4'b0101;
    push(12'h922, 2'd2, 2'd0, 1'b0, 3);
    push(12'h924, 2'd0, 2'd2, 1'b0, 2);
    push(12'h864, 2'd1, 2'd2, 1'b0, 3);
    drain(100);

`ifdef TL_PED_EN
    // 8: pedestrian pulse during home green with no vehicle demand
    reset_to(4'b0000, 4'd8);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 1);
    drain(100);
    push(12'h921, 2'd1, 2'd0, 1'b0, 7);
    push(12'h922, 2'd2, 2'd0, 1'b0, 3);
    push(12'h924, 2'd3, 2'd0, 1'b1, 10);
    push(12'h924, 2'd0, 2'd0, 1'b0, 2);
    push(12'h921, 2'd1, 2'd0, 1'b0, 5);
    ped_req = 1'b1;
    @(negedge clk);
    #1;
    ped_req = 1'b0;
    drain(100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
